tpu_tile_sequencer: RTL and testbench
=====================================

# tpu_tile_sequencer

Sequences one matrix-multiply tile through the systolic array datapath. It accepts a tile command over a valid/ready handshake and drives the buffer read ports, the weight and data FIFO enables, the MMU enables and the accumulator enable with cycle-exact timing. It replaces hand-timed per-cycle instruction words with a single command per tile. It sits between the host command path and the control inputs of the weight buffer, unified buffer, FIFOs, MMU and accumulator.

## Interface
- ARRAY_DIM, 16: MMU rows/cols; number of weight vectors loaded per tile
- ADDR_W, 8: buffer address width; addresses wrap modulo 2^ADDR_W
- ACC_DEPTH, 16: accumulator depth; maximum rows per tile
- MMU_LAT, 31: cycles from the first data-valid mat_mul cycle to the first valid MMU result row
- clk  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_w_base  in  ADDR_W  weight-buffer base address
- cmd_d_base  in  ADDR_W  unified-buffer base address
- cmd_rows  in  $clog2(ACC_DEPTH)+1  number of data vectors R; legal range is 1..ACC_DEPTH
- cmd_acc  in  1  capture results into the accumulator
- abort  in  1  synchronous cancel
- wb_enb / wb_addrb  out  1 / ADDR_W  weight-buffer read port
- ub_enb / ub_addrb  out  1 / ADDR_W  unified-buffer read port
- load_weight  out  1  weight FIFO enable and MMU wen
- load_data  out  1  data FIFO enable
- mat_mul  out  1  MMU mmen
- acc_en  out  1  accumulator enable
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a tile completes
- cmd_err  out  1  one-cycle pulse when an illegal command is rejected

## Operation
- States: IDLE, LOAD_W, STREAM, DRAIN, ACC, DONE.
- Command acceptance:
  - A command is accepted when cmd_valid && cmd_ready at a clock edge; this is cycle 0.
  - All fields are registered at acceptance.
  - If R==0 or R>ACC_DEPTH: cmd_err pulses in cycle 1 and the FSM stays in IDLE. No other output toggles.
- IDLE→LOAD_W on a legal command.
- LOAD_W lasts ARRAY_DIM cycles; k counts 0..ARRAY_DIM-1.
  - wb_enb=1, wb_addrb=w_base+k (mod 2^ADDR_W).
- STREAM lasts R cycles; j counts 0..R-1.
  - ub_enb=1, ub_addrb=d_base+j (mod 2^ADDR_W).
- The BRAM read latency is 1 cycle:
  - load_weight is wb_enb delayed by one cycle.
  - load_data is ub_enb delayed by one cycle.
- mat_mul:
  - Rises together with the first load_data cycle.
  - Stays high continuously until the last ACC cycle. The array keeps shifting during pipeline drain.
- DRAIN waits until MMU_LAT cycles have elapsed since mat_mul rose.
- ACC lasts R cycles. acc_en = cmd_acc in every ACC cycle.
- DONE lasts one cycle:
  - done=1 and busy=1 in that cycle; all datapath enables are low.
  - The FSM then returns to IDLE, and cmd_ready is high the next cycle.
- Width rules:
  - Address adders are ADDR_W bits and wrap with no error. Example: base 0xF8 with k=15 gives address 0x07.
  - Counters are sized to hold max(ARRAY_DIM, ACC_DEPTH, MMU_LAT).

## Timing
- Absolute cycles for a legal command accepted at cycle 0, with defaults (D=16, MMU_LAT=31):
  - LOAD_W: cycles 1..16. load_weight: cycles 2..17.
  - STREAM: cycles 17..16+R. load_data: cycles 18..17+R.
  - mat_mul: cycles 18..48+R.
  - ACC: cycles 49..48+R.
  - DONE: cycle 49+R.
- Transitions:
  - LOAD_W→STREAM after the last k.
  - STREAM→DRAIN after the last j.
  - DRAIN→ACC when the latency counter reaches MMU_LAT.
  - ACC→DONE after R cycles.
- Reset values: every output is 0 except cmd_ready=1. State is IDLE, and the delay registers and counters are cleared.
- reset or abort mid-tile:
  - Next cycle: IDLE, all enables 0, pipeline delay registers cleared.
  - No done pulse.
- Precedence: reset > abort > cmd_valid. An abort in IDLE is a no-op. A command offered in the same cycle as abort is not accepted.
- cmd_valid while busy: ignored; cmd_ready stays low. The command may be held until IDLE.
- Back-to-back commands: the earliest next acceptance is the cycle after DONE. Tiles never overlap.

## Structure
- Shared package tpu_ctrl_pkg holds:
  - The state enum.
  - Default ARRAY_DIM, ACC_DEPTH and MMU_LAT constants.
  - A command struct {w_base, d_base, rows, acc}.
- One sub-module, tpu_addr_gen: base register, up-counter, wrapping adder, enable output and one-cycle delayed enable. It is instantiated twice, once for the weight buffer and once for the unified buffer.
- The FSM and the latency counter live in the top module.

## Test plan
- Legal command (w_base=0x10, d_base=0x40, R=4, acc=1) at cycle 0:
  - wb_addrb runs 0x10..0x1F in cycles 1..16.
  - ub_addrb runs 0x40..0x43 in cycles 17..20.
  - mat_mul is high in cycles 18..52; acc_en is high in cycles 49..52; done pulses in cycle 53.
- Wrap: w_base=0xF8, R=1 → wb_addrb is 0xF8..0xFF, then 0x00..0x07. done pulses in cycle 50.
- Illegal commands: R=0 and R=17 → cmd_err pulses in cycle 1; busy and all enables stay 0; cmd_ready stays 1.
- acc=0 with R=16 → acc_en is never asserted; mat_mul is high in cycles 18..64; done pulses in cycle 65.
- abort at cycle 20 of an R=8 tile → all outputs 0 and cmd_ready=1 at cycle 21; no done. A new command accepted at cycle 22 replays the exact timing.
- reset asserted during ACC, and cmd_valid held high through busy, checked separately:
  - Reset during ACC → outputs reach their reset values the next cycle.
  - cmd_valid held through busy → the command is accepted only in the cycle after DONE.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// Shared types and default dimensions for the TPU tile control path.
package tpu_ctrl_pkg;

  localparam int unsigned DEF_ARRAY_DIM = 16;
  localparam int unsigned DEF_ACC_DEPTH = 16;
  localparam int unsigned DEF_MMU_LAT   = 31;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_ROWS_W    = $clog2(DEF_ACC_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_ACC,
    S_DONE
  } tile_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] w_base;
    logic [DEF_ADDR_W-1:0] d_base;
    logic [DEF_ROWS_W-1:0] rows;
    logic                  acc;
  } tile_cmd_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tpu_addr_gen.sv
// Buffer read-port sequencer: base + wrapping up-counter, enable and 1-cycle delayed enable.
module tpu_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_en_d
);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_en;
  logic              r_en_d;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_base <= '0;
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= r_en;
      if (i_load) r_base <= i_base;
      if (i_start) begin
        r_en  <= 1'b1;
        r_cnt <= '0;
      end else if (i_stop) begin
        r_en <= 1'b0;
      end else if (r_en) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
    end
  end

  // Address is forced to zero while idle so the port reads quiet between tiles.
  assign o_en   = r_en;
  assign o_addr = r_en ? (r_base + r_cnt) : '0;
  assign o_en_d = r_en_d;

endmodule

// File: rtl/tpu_tile_sequencer.sv
// Single-command tile sequencer driving buffer reads, FIFO/MMU enables and accumulator capture.
module tpu_tile_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned ARRAY_DIM = DEF_ARRAY_DIM,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned ACC_DEPTH = DEF_ACC_DEPTH,
  parameter int unsigned MMU_LAT   = DEF_MMU_LAT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_W-1:0]            cmd_w_base,
  input  logic [ADDR_W-1:0]            cmd_d_base,
  input  logic [$clog2(ACC_DEPTH):0]   cmd_rows,
  input  logic                         cmd_acc,
  input  logic                         abort,
  output logic                         wb_enb,
  output logic [ADDR_W-1:0]            wb_addrb,
  output logic                         ub_enb,
  output logic [ADDR_W-1:0]            ub_addrb,
  output logic                         load_weight,
  output logic                         load_data,
  output logic                         mat_mul,
  output logic                         acc_en,
  output logic                         busy,
  output logic                         done,
  output logic                         cmd_err
);

  localparam int unsigned ROWS_W = $clog2(ACC_DEPTH) + 1;
  localparam int unsigned CNT_W  = $clog2(max3(ARRAY_DIM, ACC_DEPTH, MMU_LAT) + 1);

  tile_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_lat;
  logic [ROWS_W-1:0] r_rows;
  logic              r_acc;
  logic              r_ready, r_busy, r_done, r_err, r_mat, r_acc_en;

  tile_cmd_t w_cmd;
  logic      w_legal, w_accept, w_kill, w_clr, w_k_last, w_j_last, w_r_last;

  assign w_cmd    = '{w_base: cmd_w_base, d_base: cmd_d_base, rows: cmd_rows, acc: cmd_acc};
  assign w_legal  = (w_cmd.rows != '0) && (w_cmd.rows <= ROWS_W'(ACC_DEPTH));
  assign w_kill   = abort && (r_state != S_IDLE);
  assign w_clr    = reset || w_kill;
  assign w_accept = (r_state == S_IDLE) && cmd_valid && r_ready && !abort && w_legal;
  assign w_r_last = (r_cnt == CNT_W'(r_rows - ROWS_W'(1)));
  assign w_k_last = (r_state == S_LOAD_W) && (r_cnt == CNT_W'(ARRAY_DIM - 1));
  assign w_j_last = (r_state == S_STREAM) && w_r_last;

  always_ff @(posedge clk) begin
    r_err <= 1'b0;
    if (reset || w_kill) begin
      r_state  <= S_IDLE;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mat    <= 1'b0;
      r_acc_en <= 1'b0;
      r_cnt    <= '0;
      r_lat    <= '0;
      r_rows   <= '0;
      r_acc    <= 1'b0;
    end else begin
      // Latency is measured from the first mat_mul cycle until ACC begins.
      if (r_mat && (r_state == S_STREAM || r_state == S_DRAIN)) r_lat <= r_lat + CNT_W'(1);
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_ready && !abort) begin
            if (w_legal) begin
              r_state <= S_LOAD_W;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              r_cnt   <= '0;
              r_lat   <= '0;
              r_rows  <= w_cmd.rows;
              r_acc   <= w_cmd.acc;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (w_k_last) begin
            r_state <= S_STREAM;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STREAM: begin
          r_mat <= 1'b1;
          if (w_j_last) r_state <= S_DRAIN;
          else          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_DRAIN: begin
          if (r_lat == CNT_W'(MMU_LAT - 1)) begin
            r_state  <= S_ACC;
            r_cnt    <= '0;
            r_acc_en <= r_acc;
          end
        end
        S_ACC: begin
          if (w_r_last) begin
            r_state  <= S_DONE;
            r_acc_en <= 1'b0;
            r_mat    <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_lat   <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tpu_addr_gen #(.ADDR_W(ADDR_W)) u_wb_gen (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_load  (w_accept),
    .i_base  (w_cmd.w_base),
    .i_start (w_accept),
    .i_stop  (w_k_last),
    .o_en    (wb_enb),
    .o_addr  (wb_addrb),
    .o_en_d  (load_weight)
  );

  tpu_addr_gen #(.ADDR_W(ADDR_W)) u_ub_gen (
    .clk     (clk),
    .i_clr   (w_clr),
    .i_load  (w_accept),
    .i_base  (w_cmd.d_base),
    .i_start (w_k_last),
    .i_stop  (w_j_last),
    .o_en    (ub_enb),
    .o_addr  (ub_addrb),
    .o_en_d  (load_data)
  );

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cmd_err   = r_err;
  assign mat_mul   = r_mat;
  assign acc_en    = r_acc_en;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed, table-driven bench for tpu_tile_sequencer with a cycle-timing reference model.
module tb_tpu_tile_sequencer;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       wb_enb;
    logic [7:0] wb_addr;
    logic       ub_enb;
    logic [7:0] ub_addr;
    logic       lw;
    logic       ld;
    logic       mm;
    logic       acc_en;
  } outs_t;

  typedef struct {
    logic [7:0] w;
    logic [7:0] d;
    logic [4:0] rows;
    logic       acc;
    logic       legal;
    int         done_cyc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, cmd_valid, cmd_acc, abort;
  logic [7:0] cmd_w_base, cmd_d_base;
  logic [4:0] cmd_rows;
  logic       cmd_ready, wb_enb, ub_enb, load_weight, load_data, mat_mul, acc_en;
  logic       busy, done, cmd_err;
  logic [7:0] wb_addrb, ub_addrb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(
    .ARRAY_DIM (16),
    .ADDR_W    (8),
    .ACC_DEPTH (16),
    .MMU_LAT   (31)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_w_base  (cmd_w_base),
    .cmd_d_base  (cmd_d_base),
    .cmd_rows    (cmd_rows),
    .cmd_acc     (cmd_acc),
    .abort       (abort),
    .wb_enb      (wb_enb),
    .wb_addrb    (wb_addrb),
    .ub_enb      (ub_enb),
    .ub_addrb    (ub_addrb),
    .load_weight (load_weight),
    .load_data   (load_data),
    .mat_mul     (mat_mul),
    .acc_en      (acc_en),
    .busy        (busy),
    .done        (done),
    .cmd_err     (cmd_err)
  );

  function automatic outs_t idle_out();
    outs_t e;
    e = '0;
    e.ready = 1'b1;
    return e;
  endfunction

  // Expected outputs c cycles after acceptance, from the absolute tile timing.
  function automatic outs_t exp_at(input vec_t v, input int c);
    outs_t e;
    int    r;
    e = '0;
    r = int'(v.rows);
    if (!v.legal) begin
      e.ready = 1'b1;
      e.err   = (c == 1);
      return e;
    end
    e.busy   = (c >= 1) && (c <= v.done_cyc);
    e.ready  = !e.busy;
    e.done   = (c == v.done_cyc);
    e.wb_enb = (c >= 1) && (c <= 16);
    if (e.wb_enb) e.wb_addr = v.w + 8'(c - 1);
    e.ub_enb = (c >= 17) && (c <= 16 + r);
    if (e.ub_enb) e.ub_addr = v.d + 8'(c - 17);
    e.lw     = (c >= 2) && (c <= 17);
    e.ld     = (c >= 18) && (c <= 17 + r);
    e.mm     = (c >= 18) && (c <= v.done_cyc - 1);
    e.acc_en = v.acc && (c >= 49) && (c <= v.done_cyc - 1);
    return e;
  endfunction

  task automatic check(input string nm, input int c, input outs_t e);
    outs_t a;
    a = '{ready: cmd_ready, busy: busy, done: done, err: cmd_err, wb_enb: wb_enb,
          wb_addr: wb_addrb, ub_enb: ub_enb, ub_addr: ub_addrb, lw: load_weight,
          ld: load_data, mm: mat_mul, acc_en: acc_en};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b (rdy,bsy,dn,err,wbe,wba,ube,uba,lw,ld,mm,acc)",
               nm, c, a, e);
    end
  endtask

  task automatic offer(input vec_t v);
    cmd_valid  = 1'b1;
    cmd_w_base = v.w;
    cmd_d_base = v.d;
    cmd_rows   = v.rows;
    cmd_acc    = v.acc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_tile(input vec_t v, input string nm);
    int last;
    offer(v);
    step();
    cmd_valid = 1'b0;
    last = v.legal ? v.done_cyc + 2 : 3;
    for (int c = 1; c <= last; c++) begin
      check(nm, c, exp_at(v, c));
      step();
    end
  endtask

  vec_t vecs[6];
  vec_t va, vr, vh;

  initial begin
    vecs[0] = '{w: 8'h10, d: 8'h40, rows: 5'd4,  acc: 1'b1, legal: 1'b1, done_cyc: 53};
    vecs[1] = '{w: 8'hF8, d: 8'h00, rows: 5'd1,  acc: 1'b1, legal: 1'b1, done_cyc: 50};
    vecs[2] = '{w: 8'h33, d: 8'h44, rows: 5'd0,  acc: 1'b1, legal: 1'b0, done_cyc: 0};
    vecs[3] = '{w: 8'h33, d: 8'h44, rows: 5'd17, acc: 1'b1, legal: 1'b0, done_cyc: 0};
    vecs[4] = '{w: 8'h20, d: 8'hFC, rows: 5'd16, acc: 1'b0, legal: 1'b1, done_cyc: 65};
    vecs[5] = '{w: 8'h00, d: 8'h80, rows: 5'd16, acc: 1'b1, legal: 1'b1, done_cyc: 65};
    va = '{w: 8'h05, d: 8'h90, rows: 5'd8, acc: 1'b1, legal: 1'b1, done_cyc: 57};
    vr = '{w: 8'hA0, d: 8'h30, rows: 5'd4, acc: 1'b1, legal: 1'b1, done_cyc: 53};
    vh = '{w: 8'h70, d: 8'h11, rows: 5'd2, acc: 1'b1, legal: 1'b1, done_cyc: 51};

    reset = 1'b1; abort = 1'b0; cmd_valid = 1'b0;
    cmd_w_base = '0; cmd_d_base = '0; cmd_rows = '0; cmd_acc = 1'b0;
    repeat (3) step();
    check("reset", 0, idle_out());
    reset = 1'b0;
    step();
    check("post_reset", 0, idle_out());

    for (int i = 0; i < 6; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

    // Abort during STREAM, then replay the same command.
    offer(va);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check("abort_pre", c, exp_at(va, c));
      if (c == 20) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check("abort_idle", 21, idle_out());
    step();
    check("abort_idle2", 22, idle_out());
    run_tile(va, "abort_replay");

    // Abort in IDLE blocks a simultaneous command.
    offer(va);
    abort = 1'b1;
    step();
    cmd_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort", 1, idle_out());
    step();
    check("idle_abort2", 2, idle_out());

    // Reset during ACC.
    offer(vr);
    step();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      check("rst_pre", c, exp_at(vr, c));
      if (c == 50) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    check("rst_acc", 51, idle_out());
    step();
    check("rst_acc2", 52, idle_out());

    // cmd_valid held through the tile: second acceptance lands right after DONE.
    offer(vh);
    step();
    for (int c = 1; c <= vh.done_cyc + 1; c++) begin
      check("hold_first", c, exp_at(vh, c));
      step();
    end
    check("hold_second", 1, exp_at(vh, 1));
    cmd_valid = 1'b0;
    step();
    for (int c = 2; c <= vh.done_cyc + 2; c++) begin
      check("hold_second", c, exp_at(vh, c));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
